// File: rtl/mips_multicycle_control_if.sv
// Memory request/ready bundle between the multicycle control FSM and the
// unified instruction/data memory. The controller is the master: it issues
// mem_req/mem_we/iord and waits for mem_ready.
interface mips_multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. It sequences the fetch,
// decode, execute, memory and writeback steps. It also keeps a count of
// retired instructions.
// Optional build macro MIPS_ILLEGAL_TRAP_EN: when it is defined, an
// unsupported opcode locks the FSM in TRAP and raises illegal_op. When it is
// undefined, an unsupported opcode retires as a NOP.
module mips_multicycle_control #(
    parameter int OPCODE_LEN = 6,
    parameter int COUNT_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_control_if.master mem,
    input  logic [OPCODE_LEN-1:0] opcode,
    input  logic                  zero,
    output logic                  ir_write,
    output logic                  decode_enable,
    output logic [1:0]            decode_type,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [1:0]            pc_src,
    output logic                  pc_en,
    output logic [COUNT_LEN-1:0]  instr_count
`ifdef MIPS_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_op
`endif
);

    localparam logic [OPCODE_LEN-1:0] OP_R    = OPCODE_LEN'(6'b000000);
    localparam logic [OPCODE_LEN-1:0] OP_LW   = OPCODE_LEN'(6'b100011);
    localparam logic [OPCODE_LEN-1:0] OP_SW   = OPCODE_LEN'(6'b101011);
    localparam logic [OPCODE_LEN-1:0] OP_BEQ  = OPCODE_LEN'(6'b000100);
    localparam logic [OPCODE_LEN-1:0] OP_ADDI = OPCODE_LEN'(6'b001000);
    localparam logic [OPCODE_LEN-1:0] OP_ANDI = OPCODE_LEN'(6'b001100);
    localparam logic [OPCODE_LEN-1:0] OP_ORI  = OPCODE_LEN'(6'b001101);
    localparam logic [OPCODE_LEN-1:0] OP_J    = OPCODE_LEN'(6'b000010);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP, TRAP
    } state_t;

    state_t state, next;
    logic   pc_write, pc_write_cond, retire;

    logic is_r, is_lw, is_sw, is_beq, is_addi, is_logic_imm, is_j;
    assign is_r         = (opcode == OP_R);
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign is_beq       = (opcode == OP_BEQ);
    assign is_addi      = (opcode == OP_ADDI);
    assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_j         = (opcode == OP_J);

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Retired-instruction counter; it wraps naturally at 2^COUNT_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + COUNT_LEN'(1);
    end

    // Next-state and Moore outputs. Only the FETCH strobes look at mem_ready.
    always_comb begin
        next          = state;
        retire        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.iord      = 1'b0;
        ir_write      = 1'b0;
        decode_enable = 1'b0;
        decode_type   = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_src        = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'd1;
                ir_write    = mem.mem_ready;
                pc_write    = mem.mem_ready;
                if (mem.mem_ready) next = DECODE;
            end
            DECODE: begin
                decode_enable = 1'b1;
                decode_type   = is_r ? 2'd0 : (is_j ? 2'd2 : 2'd1);
                alu_src_b     = 2'd3;
                if (is_lw || is_sw)                next = MEMADR;
                else if (is_r)                     next = EXEC;
                else if (is_beq)                   next = BRANCH;
                else if (is_addi || is_logic_imm)  next = IMMEXEC;
                else if (is_j)                     next = JUMP;
                else begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                    next   = TRAP;
`else
                    next   = FETCH;
                    retire = 1'b1;
`endif
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                next      = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                if (mem.mem_ready) next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next       = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.iord    = 1'b1;
                if (mem.mem_ready) begin
                    next   = FETCH;
                    retire = 1'b1;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                next      = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                next      = FETCH;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_src        = 2'd1;
                pc_write_cond = 1'b1;
                next          = FETCH;
                retire        = 1'b1;
            end
            IMMEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = is_logic_imm ? 2'd3 : 2'd0;
                next      = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
                next      = FETCH;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
                next     = FETCH;
                retire   = 1'b1;
            end
            TRAP:    next = TRAP;
            default: next = IDLE;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

`ifdef MIPS_ILLEGAL_TRAP_EN
    // TRAP is terminal until reset, so decoding the state is already sticky.
    assign illegal_op = (state == TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. A table of per-cycle
// {inputs, expected outputs} records is stepped through, and expectations go
// through a scoreboard queue. Hand-written sequences cover mid-transaction
// reset and the illegal-opcode path.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode;
    logic        zero;
    logic        ir_write, decode_enable, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en;
    logic [1:0]  decode_type, alu_src_b, alu_op, pc_src;
    logic [31:0] instr_count;
`ifdef MIPS_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    mips_multicycle_control_if bus();

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .mem(bus), .opcode(opcode), .zero(zero),
        .ir_write(ir_write), .decode_enable(decode_enable), .decode_type(decode_type),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_en(pc_en), .instr_count(instr_count)
`ifdef MIPS_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_req, mem_we, iord, ir_write, decode_enable;
        logic [1:0]  decode_type;
        logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0]  alu_src_b, alu_op, pc_src;
        logic        pc_en, illegal_op;
        logic [31:0] cnt;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    typedef struct {
        string name;
        outs_t exp;
    } sb_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    vec_t  vecs[$];
    sb_t   sb[$];
    int    errors = 0;
    int    checks = 0;
    outs_t act;

    // Sample the DUT outputs into the same layout as the expectations.
    always_comb begin
        act             = '0;
        act.mem_req     = bus.mem_req;
        act.mem_we      = bus.mem_we;
        act.iord        = bus.iord;
        act.ir_write    = ir_write;
        act.decode_enable = decode_enable;
        act.decode_type = decode_type;
        act.reg_write   = reg_write;
        act.reg_dst     = reg_dst;
        act.mem_to_reg  = mem_to_reg;
        act.alu_src_a   = alu_src_a;
        act.alu_src_b   = alu_src_b;
        act.alu_op      = alu_op;
        act.pc_src      = pc_src;
        act.pc_en       = pc_en;
`ifdef MIPS_ILLEGAL_TRAP_EN
        act.illegal_op  = illegal_op;
`endif
        act.cnt         = instr_count;
    end

    // Expected outputs per state.
    function automatic outs_t e_zero(int c);
        outs_t o = '0; o.cnt = c; return o;
    endfunction
    function automatic outs_t e_fetch(logic rdy, int c);
        outs_t o = e_zero(c); o.mem_req = 1; o.alu_src_b = 1; o.ir_write = rdy; o.pc_en = rdy; return o;
    endfunction
    function automatic outs_t e_decode(logic [1:0] dt, int c);
        outs_t o = e_zero(c); o.decode_enable = 1; o.decode_type = dt; o.alu_src_b = 3; return o;
    endfunction
    function automatic outs_t e_memadr(int c);
        outs_t o = e_zero(c); o.alu_src_a = 1; o.alu_src_b = 2; return o;
    endfunction
    function automatic outs_t e_memrd(int c);
        outs_t o = e_zero(c); o.mem_req = 1; o.iord = 1; return o;
    endfunction
    function automatic outs_t e_memwb(int c);
        outs_t o = e_zero(c); o.reg_write = 1; o.mem_to_reg = 1; return o;
    endfunction
    function automatic outs_t e_memwr(int c);
        outs_t o = e_zero(c); o.mem_req = 1; o.mem_we = 1; o.iord = 1; return o;
    endfunction
    function automatic outs_t e_exec(int c);
        outs_t o = e_zero(c); o.alu_src_a = 1; o.alu_op = 2; return o;
    endfunction
    function automatic outs_t e_aluwb(int c);
        outs_t o = e_zero(c); o.reg_write = 1; o.reg_dst = 1; return o;
    endfunction
    function automatic outs_t e_branch(logic z, int c);
        outs_t o = e_zero(c); o.alu_src_a = 1; o.alu_op = 1; o.pc_src = 1; o.pc_en = z; return o;
    endfunction
    function automatic outs_t e_imm(logic [1:0] op, int c);
        outs_t o = e_zero(c); o.alu_src_a = 1; o.alu_src_b = 2; o.alu_op = op; return o;
    endfunction
    function automatic outs_t e_immwb(int c);
        outs_t o = e_zero(c); o.reg_write = 1; return o;
    endfunction
    function automatic outs_t e_jump(int c);
        outs_t o = e_zero(c); o.pc_src = 2; o.pc_en = 1; return o;
    endfunction

    task automatic add(input string n, input logic [5:0] op, input logic z, input logic rdy, input outs_t e);
        vec_t v;
        v.name = n; v.op = op; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic compare_pop();
        sb_t s;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        s = sb.pop_front();
        checks++;
        if (act !== s.exp)
            begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end
    endtask

    // Drive one cycle of inputs, queue its expectation, and check at the falling edge.
    task automatic chk(input string n, input logic [5:0] op, input logic z, input logic rdy, input outs_t e);
        opcode = op; zero = z; bus.mem_ready = rdy;
        sb.push_back('{n, e});
        @(negedge clk);
        compare_pop();
    endtask

    task automatic step(input string n, input logic [5:0] op, input logic z, input logic rdy, input outs_t e);
        @(posedge clk); #1;
        chk(n, op, z, rdy, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        outs_t t;
        opcode = R; zero = 1'b0; bus.mem_ready = 1'b1;

        add("r_fetch",     R,    0, 1, e_fetch(1, 0));
        add("r_decode",    R,    0, 1, e_decode(0, 0));
        add("r_exec",      R,    0, 0, e_exec(0));
        add("r_aluwb",     R,    0, 1, e_aluwb(0));
        add("lw_fetch",    LW,   0, 1, e_fetch(1, 1));
        add("lw_decode",   LW,   0, 1, e_decode(1, 1));
        add("lw_memadr",   LW,   0, 1, e_memadr(1));
        add("lw_memrd0",   LW,   0, 0, e_memrd(1));
        add("lw_memrd1",   LW,   0, 0, e_memrd(1));
        add("lw_memrd2",   LW,   0, 0, e_memrd(1));
        add("lw_memrd3",   LW,   0, 1, e_memrd(1));
        add("lw_memwb",    LW,   0, 1, e_memwb(1));
        add("beq1_fetch",  BEQ,  1, 1, e_fetch(1, 2));
        add("beq1_decode", BEQ,  1, 1, e_decode(1, 2));
        add("beq1_branch", BEQ,  1, 1, e_branch(1, 2));
        add("beq0_fetch",  BEQ,  0, 1, e_fetch(1, 3));
        add("beq0_decode", BEQ,  0, 1, e_decode(1, 3));
        add("beq0_branch", BEQ,  0, 1, e_branch(0, 3));
        add("j_fetch",     J,    0, 1, e_fetch(1, 4));
        add("j_decode",    J,    0, 1, e_decode(2, 4));
        add("j_jump",      J,    0, 1, e_jump(4));
        add("andi_fetch",  ANDI, 0, 1, e_fetch(1, 5));
        add("andi_decode", ANDI, 0, 1, e_decode(1, 5));
        add("andi_exec",   ANDI, 0, 1, e_imm(3, 5));
        add("andi_wb",     ANDI, 0, 1, e_immwb(5));
        add("ori_fetch",   ORI,  0, 1, e_fetch(1, 6));
        add("ori_decode",  ORI,  0, 1, e_decode(1, 6));
        add("ori_exec",    ORI,  0, 1, e_imm(3, 6));
        add("ori_wb",      ORI,  0, 1, e_immwb(6));
        add("addi_fetch",  ADDI, 0, 1, e_fetch(1, 7));
        add("addi_decode", ADDI, 0, 1, e_decode(1, 7));
        add("addi_exec",   ADDI, 0, 1, e_imm(0, 7));
        add("addi_wb",     ADDI, 0, 1, e_immwb(7));
        add("sw_fetch_st", SW,   0, 0, e_fetch(0, 8));
        add("sw_fetch",    SW,   0, 1, e_fetch(1, 8));
        add("sw_decode",   SW,   0, 1, e_decode(1, 8));
        add("sw_memadr",   SW,   0, 1, e_memadr(8));
        add("sw_memwr0",   SW,   0, 0, e_memwr(8));
        add("sw_memwr1",   SW,   0, 0, e_memwr(8));

        // Reset state, then release into IDLE.
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{"reset", e_zero(0)});
        compare_pop();
        rst_n = 1'b1;
        chk("idle", R, 0, 1, e_zero(0));

        foreach (vecs[i]) step(vecs[i].name, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].exp);

        // Reset mid-MEMWR with mem_ready low: the request must drop at once.
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{"rst_mid_wr", e_zero(0)});
        compare_pop();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_idle", R, 0, 1, e_zero(0));
        step("rst_fetch", BAD, 0, 1, e_fetch(1, 0));
        step("bad_decode", BAD, 0, 1, e_decode(1, 0));
`ifdef MIPS_ILLEGAL_TRAP_EN
        t = e_zero(0);
        t.illegal_op = 1'b1;
        for (int k = 0; k < 20; k++) step("trap_hold", BAD, k[0], 1, t);
`else
        t = e_fetch(1, 1);
        step("bad_nop_fetch", R, 0, 1, t);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
